// File: rtl/cpu_state_seq.sv
// Multi-cycle instruction sequencer: one-hot PC->IF->ID->EX->(MA)->WB stepping with
// start/stop, single-step, memory-wait timeout and retired-instruction counting.
module cpu_state_seq #(
    parameter int INSTRET_W   = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cpu_start,
    input  logic                 cpu_stop,
    input  logic                 step_mode,
    input  logic                 step_req,
    input  logic                 if_ready,
    input  logic                 ma_req,
    input  logic                 ma_ready,
    input  logic                 instret_clr,
    output logic                 cpu_stat_pc,
    output logic                 cpu_stat_if,
    output logic                 cpu_stat_id,
    output logic                 cpu_stat_ex,
    output logic                 cpu_stat_ma,
    output logic                 cpu_stat_wb,
    output logic                 cpu_running,
    output logic                 cpu_halted,
    output logic                 bus_timeout,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [6:0] {
        S_IDLE = 7'b0000001,
        S_PC   = 7'b0000010,
        S_IF   = 7'b0000100,
        S_ID   = 7'b0001000,
        S_EX   = 7'b0010000,
        S_MA   = 7'b0100000,
        S_WB   = 7'b1000000
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    state_t     state_next;
    logic       stop_pend;
    logic       stop_pend_next;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    logic       wait_last;

    assign wait_last = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            stop_pend <= 1'b0;
            wait_cnt  <= 8'd0;
            instret   <= '0;
        end else begin
            state     <= state_next;
            stop_pend <= stop_pend_next;
            wait_cnt  <= wait_cnt_next;
            // A clear in the retiring cycle wins over the increment.
            if (instret_clr)
                instret <= '0;
            else if (state == S_WB)
                instret <= instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        state_next     = state;
        bus_timeout    = 1'b0;
        stop_pend_next = stop_pend;
        wait_cnt_next  = wait_cnt;

        case (state)
            S_IDLE: begin
                if (cpu_start || (step_mode && step_req))
                    state_next = S_PC;
            end
            S_PC: state_next = S_IF;
            S_IF: begin
                if (if_ready) begin
                    state_next = S_ID;
                end else if (wait_last) begin
                    state_next  = S_ID;
                    bus_timeout = 1'b1;
                end
            end
            S_ID: state_next = S_EX;
            S_EX: state_next = ma_req ? S_MA : S_WB;
            S_MA: begin
                if (ma_ready) begin
                    state_next = S_WB;
                end else if (wait_last) begin
                    state_next  = S_WB;
                    bus_timeout = 1'b1;
                end
            end
            // A stop arriving in the WB cycle itself still halts at this boundary.
            S_WB: state_next = (stop_pend || cpu_stop || step_mode) ? S_IDLE : S_PC;
            default: state_next = S_IDLE;
        endcase

        if (state_next == S_IDLE)
            stop_pend_next = 1'b0;
        else if (cpu_stop && state != S_IDLE)
            stop_pend_next = 1'b1;

        // Every state change restarts the wait counter, so IF/MA always enter at zero.
        if (state_next != state)
            wait_cnt_next = 8'd0;
        else if ((state == S_IF && !if_ready) || (state == S_MA && !ma_ready))
            wait_cnt_next = wait_cnt + 8'd1;
    end

    assign cpu_stat_pc = state[1];
    assign cpu_stat_if = state[2];
    assign cpu_stat_id = state[3];
    assign cpu_stat_ex = state[4];
    assign cpu_stat_ma = state[5];
    assign cpu_stat_wb = state[6];
    assign cpu_halted  = state[0];
    assign cpu_running = ~state[0];

endmodule

// File: tb/tb_cpu_state_seq.sv
// Directed bench for cpu_state_seq: normal flow, MA wait, IF timeout, stop,
// single-step, async reset and instret clear.
module tb_cpu_state_seq;

    localparam logic [5:0] ST_NONE = 6'b000000;
    localparam logic [5:0] ST_PC   = 6'b100000;
    localparam logic [5:0] ST_IF   = 6'b010000;
    localparam logic [5:0] ST_ID   = 6'b001000;
    localparam logic [5:0] ST_EX   = 6'b000100;
    localparam logic [5:0] ST_MA   = 6'b000010;
    localparam logic [5:0] ST_WB   = 6'b000001;

    logic        clk;
    logic        rst_n;
    logic        cpu_start;
    logic        cpu_stop;
    logic        step_mode;
    logic        step_req;
    logic        if_ready;
    logic        ma_req;
    logic        ma_ready;
    logic        instret_clr;
    logic        cpu_stat_pc;
    logic        cpu_stat_if;
    logic        cpu_stat_id;
    logic        cpu_stat_ex;
    logic        cpu_stat_ma;
    logic        cpu_stat_wb;
    logic        cpu_running;
    logic        cpu_halted;
    logic        bus_timeout;
    logic [63:0] instret;
    logic [5:0]  stat;

    int checks;
    int errors;

    cpu_state_seq #(
        .INSTRET_W  (64),
        .TIMEOUT_CYC(255)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_start  (cpu_start),
        .cpu_stop   (cpu_stop),
        .step_mode  (step_mode),
        .step_req   (step_req),
        .if_ready   (if_ready),
        .ma_req     (ma_req),
        .ma_ready   (ma_ready),
        .instret_clr(instret_clr),
        .cpu_stat_pc(cpu_stat_pc),
        .cpu_stat_if(cpu_stat_if),
        .cpu_stat_id(cpu_stat_id),
        .cpu_stat_ex(cpu_stat_ex),
        .cpu_stat_ma(cpu_stat_ma),
        .cpu_stat_wb(cpu_stat_wb),
        .cpu_running(cpu_running),
        .cpu_halted (cpu_halted),
        .bus_timeout(bus_timeout),
        .instret    (instret)
    );

    assign stat = {cpu_stat_pc, cpu_stat_if, cpu_stat_id, cpu_stat_ex, cpu_stat_ma, cpu_stat_wb};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_stat(input string tag, input logic [5:0] exp);
        check_eq(tag, 64'(stat), 64'(exp));
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        check_eq(tag, 64'(got), 64'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] t1_seq [10];

    initial begin
        checks = 0;
        errors = 0;
        t1_seq = '{ST_PC, ST_IF, ST_ID, ST_EX, ST_WB, ST_PC, ST_IF, ST_ID, ST_EX, ST_WB};
        rst_n = 1'b0;
        cpu_start = 1'b0; cpu_stop = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        if_ready = 1'b0; ma_req = 1'b0; ma_ready = 1'b0; instret_clr = 1'b0;

        // Reset state
        step(); step();
        check_stat("rst_stat", ST_NONE);
        check_bit("rst_halted", cpu_halted, 1'b1);
        check_bit("rst_running", cpu_running, 1'b0);
        check_bit("rst_timeout", bus_timeout, 1'b0);
        check_eq("rst_instret", instret, 64'd0);
        rst_n = 1'b1;
        step();
        check_stat("idle_hold", ST_NONE);

        // Back-to-back 5-cycle instructions
        if_ready = 1'b1;
        cpu_start = 1'b1;
        step();
        cpu_start = 1'b0;
        check_bit("t1_running", cpu_running, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check_stat("t1_state", t1_seq[i]);
            check_eq("t1_instret", instret, 64'(i / 5));
            step();
        end
        check_stat("t1_pc_again", ST_PC);
        check_eq("t1_instret_10cyc", instret, 64'd2);

        // MA held four cycles, ready on the fourth
        ma_req = 1'b1;
        ma_ready = 1'b0;
        step(); step(); step(); step();
        for (int i = 0; i < 3; i++) begin
            check_stat("t2_ma_wait", ST_MA);
            check_bit("t2_no_timeout", bus_timeout, 1'b0);
            step();
        end
        check_stat("t2_ma_last", ST_MA);
        ma_ready = 1'b1;
        check_bit("t2_no_timeout_rdy", bus_timeout, 1'b0);
        step();
        ma_req = 1'b0;
        ma_ready = 1'b0;
        check_stat("t2_wb", ST_WB);
        step();
        check_eq("t2_instret", instret, 64'd3);

        // IF timeout after 255 cycles
        if_ready = 1'b0;
        step();
        for (int n = 1; n < 255; n++) begin
            check_stat("t3_if_wait", ST_IF);
            check_bit("t3_no_pulse", bus_timeout, 1'b0);
            step();
        end
        check_stat("t3_if_last", ST_IF);
        check_bit("t3_pulse", bus_timeout, 1'b1);
        step();
        check_stat("t3_id", ST_ID);
        check_bit("t3_pulse_gone", bus_timeout, 1'b0);
        if_ready = 1'b1;
        step(); step(); step();
        check_stat("t3_pc", ST_PC);
        check_eq("t3_instret", instret, 64'd4);

        // Stop pulsed in IF completes the instruction then halts
        step();
        cpu_stop = 1'b1;
        step();
        cpu_stop = 1'b0;
        check_stat("t5_id", ST_ID);
        step(); step();
        check_stat("t5_wb", ST_WB);
        step();
        check_stat("t5_idle", ST_NONE);
        check_bit("t5_halted", cpu_halted, 1'b1);
        check_eq("t5_instret", instret, 64'd5);
        step();
        check_stat("t5_idle_hold", ST_NONE);
        cpu_stop = 1'b1;
        step();
        cpu_stop = 1'b0;
        check_stat("t5_stop_in_idle", ST_NONE);
        cpu_stop = 1'b1;
        cpu_start = 1'b1;
        step();
        cpu_stop = 1'b0;
        cpu_start = 1'b0;
        check_stat("t5_start_wins", ST_PC);
        step(); step(); step(); step();
        check_stat("t5_wb2", ST_WB);
        step();
        check_stat("t5_no_stale_stop", ST_PC);
        check_eq("t5_instret2", instret, 64'd6);
        step(); step(); step(); step();
        check_stat("t5_wb3", ST_WB);
        cpu_stop = 1'b1;
        step();
        cpu_stop = 1'b0;
        check_stat("t5_stop_at_wb", ST_NONE);
        check_eq("t5_instret3", instret, 64'd7);

        // Single-step mode
        step_req = 1'b1;
        step();
        step_req = 1'b0;
        check_stat("t4_req_no_mode", ST_NONE);
        step_mode = 1'b1;
        cpu_start = 1'b1;
        step();
        cpu_start = 1'b0;
        check_stat("t4_start", ST_PC);
        step(); step(); step(); step();
        check_stat("t4_wb", ST_WB);
        step();
        check_stat("t4_idle", ST_NONE);
        check_bit("t4_halted", cpu_halted, 1'b1);
        check_eq("t4_instret", instret, 64'd8);
        step();
        check_stat("t4_idle_hold", ST_NONE);
        for (int k = 0; k < 2; k++) begin
            step_req = 1'b1;
            step();
            step_req = 1'b0;
            check_stat("t4_step_pc", ST_PC);
            step(); step(); step(); step();
            check_stat("t4_step_wb", ST_WB);
            step();
            check_stat("t4_step_idle", ST_NONE);
            check_eq("t4_step_instret", instret, 64'(9 + k));
        end
        step_mode = 1'b0;

        // instret_clr wins over the WB increment
        cpu_start = 1'b1;
        step();
        cpu_start = 1'b0;
        step(); step(); step(); step();
        check_stat("t6_wb", ST_WB);
        check_eq("t6_instret_pre", instret, 64'd10);
        instret_clr = 1'b1;
        step();
        instret_clr = 1'b0;
        check_stat("t6_pc", ST_PC);
        check_eq("t6_clr", instret, 64'd0);
        step(); step(); step(); step(); step();
        check_eq("t6_after_clr", instret, 64'd1);

        // Asynchronous reset in the middle of MA
        ma_req = 1'b1;
        ma_ready = 1'b0;
        step(); step(); step(); step();
        check_stat("t6_ma", ST_MA);
        #2 rst_n = 1'b0;
        #1;
        check_stat("t6_rst_stat", ST_NONE);
        check_bit("t6_rst_halted", cpu_halted, 1'b1);
        check_bit("t6_rst_running", cpu_running, 1'b0);
        check_bit("t6_rst_timeout", bus_timeout, 1'b0);
        check_eq("t6_rst_instret", instret, 64'd0);
        step();
        rst_n = 1'b1;
        ma_req = 1'b0;
        step();
        check_stat("t6_post_rst_idle", ST_NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
